// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a command/response handshake
module axi_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_write_q, rsp_write_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        state_d   = WR;
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                    end else begin
                        state_d   = RD_ADDR;
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                    end
                end
            end

            // AW and W retire independently; each valid drops for good once its handshake is seen
            WR: begin
                if (awvalid_q && m_axi_awready) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (wvalid_q && m_axi_wready) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end

            WR_RESP: begin
                if (bready_q && m_axi_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi_bresp;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RD_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rready_q && m_axi_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = m_axi_rdata;
                    rsp_resp_d  = m_axi_rresp;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RSP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_resp_q  <= 2'b00;
            rsp_rdata_q <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_rdata_q <= rsp_rdata_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master with a delay-configurable slave model
module tb_axi_lite_master;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected items; rsp entries are packed {write, resp, rdata}
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic [31:0] exp_ar[$];
    logic [34:0] exp_rsp[$];

    int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    int m_aw_first, m_aw_cnt, m_w_first, m_w_cnt, m_ar_first, m_ar_cnt;
    int m_b_first, m_r_first, m_rsp_first, m_rsp_cnt;
    bit m_aw_stable, m_rsp_stable, m_cr_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_nonempty(input string name, input int size);
        n_checks++;
        if (size == 0) begin
            n_errors++;
            $display("FAIL %s: got unexpected handshake expected none", name);
        end
    endtask

    // Slave model: each ready rises after its configured number of stalled valid cycles
    initial begin
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_st, w_st, ar_st;
        bit aw_got = 0, w_got = 0, r_pend = 0;
        int aw_c = 0, w_c = 0, ar_c = 0, r_wait = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
        forever begin
            @(negedge aclk);
            aw_hs = m_axi_awvalid && m_axi_awready;  aw_st = m_axi_awvalid && !m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;    w_st  = m_axi_wvalid && !m_axi_wready;
            ar_hs = m_axi_arvalid && m_axi_arready;  ar_st = m_axi_arvalid && !m_axi_arready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            @(posedge aclk); #1;
            if (!aresetn) begin
                aw_got = 0; w_got = 0; r_pend = 0; aw_c = 0; w_c = 0; ar_c = 0;
                m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
                m_axi_bvalid = 0; m_axi_rvalid = 0;
                continue;
            end
            if (aw_hs) begin aw_c = 0; aw_got = 1; end else if (aw_st) aw_c++;
            if (w_hs)  begin w_c = 0;  w_got = 1;  end else if (w_st)  w_c++;
            if (ar_hs) begin ar_c = 0; r_pend = 1; r_wait = cfg_r_dly; end else if (ar_st) ar_c++;
            if (b_hs) m_axi_bvalid = 0;
            if (r_hs) m_axi_rvalid = 0;
            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0;
                m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
            end
            if (r_pend) begin
                if (r_wait == 0) begin
                    r_pend = 0; m_axi_rvalid = 1; m_axi_rdata = cfg_rdata; m_axi_rresp = cfg_rresp;
                end else r_wait--;
            end
            m_axi_awready = m_axi_awvalid && (aw_c >= cfg_aw_dly);
            m_axi_wready  = m_axi_wvalid && (w_c >= cfg_w_dly);
            m_axi_arready = m_axi_arvalid && (ar_c >= cfg_ar_dly);
        end
    end

    // Monitor: pops and compares whenever a handshake is presented
    initial begin
        logic [31:0] ea;
        logic [35:0] ew;
        logic [34:0] er;
        forever begin
            @(negedge aclk); #1;
            if (aresetn) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    check_nonempty("aw_unexpected", exp_aw.size());
                    if (exp_aw.size() > 0) begin ea = exp_aw.pop_front(); check("aw_addr", m_axi_awaddr, ea); end
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    check_nonempty("w_unexpected", exp_w.size());
                    if (exp_w.size() > 0) begin ew = exp_w.pop_front(); check("w_data_strb", {m_axi_wstrb, m_axi_wdata}, ew); end
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    check_nonempty("ar_unexpected", exp_ar.size());
                    if (exp_ar.size() > 0) begin ea = exp_ar.pop_front(); check("ar_addr", m_axi_araddr, ea); end
                end
                if (rsp_valid && rsp_ready) begin
                    check_nonempty("rsp_unexpected", exp_rsp.size());
                    if (exp_rsp.size() > 0) begin er = exp_rsp.pop_front(); check("rsp_fields", {rsp_write, rsp_resp, rsp_rdata}, er); end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic exp_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
        exp_rsp.push_back({1'b1, r, 32'h0});
    endtask

    task automatic exp_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
        exp_ar.push_back(a);
        exp_rsp.push_back({1'b0, r, d});
    endtask

    // Called just after a rising edge; the command is accepted on the next edge (cycle 0)
    task automatic do_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        while (!cmd_ready && n < 20) begin @(posedge aclk); #1; n++; end
        check("cmd_ready_before_cmd", cmd_ready, 1'b1);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        @(posedge aclk); #1;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    endtask

    // Records per-cycle activity from cycle 1 until the response handshake
    task automatic observe(input int hold);
        int k = 1, stall = 0;
        bit done = 0;
        logic [34:0] er = '0;
        logic [31:0] ea = '0;
        m_aw_first = 0; m_aw_cnt = 0; m_w_first = 0; m_w_cnt = 0; m_ar_first = 0; m_ar_cnt = 0;
        m_b_first = 0; m_r_first = 0; m_rsp_first = 0; m_rsp_cnt = 0;
        m_aw_stable = 1; m_rsp_stable = 1; m_cr_low = 1;
        if (exp_aw.size() > 0) ea = exp_aw[0];
        if (exp_rsp.size() > 0) er = exp_rsp[0];
        rsp_ready = (hold == 0);
        while (k < 60) begin
            @(negedge aclk);
            if (m_axi_awvalid) begin
                if (m_aw_cnt == 0) m_aw_first = k;
                if (m_axi_awaddr !== ea) m_aw_stable = 0;
                m_aw_cnt++;
            end
            if (m_axi_wvalid) begin if (m_w_cnt == 0) m_w_first = k; m_w_cnt++; end
            if (m_axi_arvalid) begin if (m_ar_cnt == 0) m_ar_first = k; m_ar_cnt++; end
            if (m_axi_bready && m_b_first == 0) m_b_first = k;
            if (m_axi_rready && m_r_first == 0) m_r_first = k;
            if (cmd_ready) m_cr_low = 0;
            if (rsp_valid) begin
                if (m_rsp_cnt == 0) m_rsp_first = k;
                if ({rsp_write, rsp_resp, rsp_rdata} !== er) m_rsp_stable = 0;
                m_rsp_cnt++;
                if (!rsp_ready) stall++;
            end
            if (rsp_valid && rsp_ready) begin
                @(posedge aclk); #1;
                done = 1;
                check("cmd_ready_after_rsp", cmd_ready, 1'b1);
                check("rsp_valid_dropped", rsp_valid, 1'b0);
                check("rsp_fields_held", {rsp_write, rsp_resp, rsp_rdata}, er);
                break;
            end
            @(posedge aclk); #1;
            k++;
            if (stall >= hold) rsp_ready = 1;
        end
        check("txn_completed", done, 1'b1);
        rsp_ready = 1;
    endtask

    task automatic set_slave(input int aw, input int w, input int ar, input int r);
        cfg_aw_dly = aw; cfg_w_dly = w; cfg_ar_dly = ar; cfg_r_dly = r;
    endtask

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
        repeat (3) @(posedge aclk); #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}, 6'b0);
        check("rst_addr_data", {m_axi_awaddr, m_axi_araddr}, 64'h0);
        check("rst_wdata_strb", {m_axi_wstrb, m_axi_wdata}, 36'h0);
        check("rst_rsp", {rsp_write, rsp_resp, rsp_rdata}, 35'h0);
        check("prot", {m_axi_awprot, m_axi_arprot}, 6'b0);
        aresetn = 1;
        @(posedge aclk); #1;

        // Minimum-latency write
        set_slave(0, 0, 0, 0); cfg_bresp = 2'b00;
        exp_write(32'h0, 32'h3, 4'hF, 2'b00);
        do_cmd(1, 32'h0, 32'h3, 4'hF); observe(0);
        check("t1_aw_first", m_aw_first, 1); check("t1_aw_cnt", m_aw_cnt, 1);
        check("t1_w_first", m_w_first, 1);  check("t1_w_cnt", m_w_cnt, 1);
        check("t1_b_first", m_b_first, 2);  check("t1_rsp_first", m_rsp_first, 3);
        check("t1_cmd_ready_low", m_cr_low, 1'b1);

        // awready delayed three cycles, wready immediate
        set_slave(3, 0, 0, 0);
        exp_write(32'h8, 32'hA5A5_0001, 4'h3, 2'b00);
        do_cmd(1, 32'h8, 32'hA5A5_0001, 4'h3); observe(0);
        check("t2_aw_cnt", m_aw_cnt, 4); check("t2_aw_stable", m_aw_stable, 1'b1);
        check("t2_w_cnt", m_w_cnt, 1);   check("t2_b_first", m_b_first, 5);
        check("t2_rsp_first", m_rsp_first, 6);

        // Read with rvalid two cycles after arready
        set_slave(0, 0, 0, 1); cfg_rdata = 32'h9; cfg_rresp = 2'b00;
        exp_read(32'h4, 32'h9, 2'b00);
        do_cmd(0, 32'h4, 32'h0, 4'h0); observe(0);
        check("t3_ar_first", m_ar_first, 1); check("t3_ar_cnt", m_ar_cnt, 1);
        check("t3_r_first", m_r_first, 2);   check("t3_rsp_first", m_rsp_first, 4);
        check("t3_no_aw", m_aw_cnt, 0);

        // SLVERR write, W delayed so AW completes first
        set_slave(0, 2, 0, 0); cfg_bresp = 2'b10;
        exp_write(32'hC, 32'hFF, 4'h1, 2'b10);
        do_cmd(1, 32'hC, 32'hFF, 4'h1); observe(0);
        check("t4_aw_cnt", m_aw_cnt, 1); check("t4_w_cnt", m_w_cnt, 3);
        check("t4_b_first", m_b_first, 4); check("t4_rsp_first", m_rsp_first, 5);

        // DECERR read with arready delayed and consumer stalling for five cycles
        set_slave(0, 0, 2, 0); cfg_bresp = 2'b00; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b11;
        exp_read(32'h10, 32'hDEAD_BEEF, 2'b11);
        do_cmd(0, 32'h10, 32'h0, 4'h0); observe(5);
        check("t5_ar_cnt", m_ar_cnt, 3);     check("t5_r_first", m_r_first, 4);
        check("t5_rsp_first", m_rsp_first, 5); check("t5_rsp_cnt", m_rsp_cnt, 6);
        check("t5_rsp_stable", m_rsp_stable, 1'b1); check("t5_cmd_ready_low", m_cr_low, 1'b1);

        // Reset while AW is stalled
        set_slave(100, 0, 0, 0);
        exp_write(32'h20, 32'h1234, 4'hF, 2'b00);
        do_cmd(1, 32'h20, 32'h1234, 4'hF);
        @(negedge aclk);
        check("t6_awvalid_pre", m_axi_awvalid, 1'b1);
        #2;
        aresetn = 0;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_rsp.delete();
        #1;
        check("t6_valids_async", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready, rsp_valid}, 6'b0);
        check("t6_cmd_ready_async", cmd_ready, 1'b1);
        check("t6_awaddr_async", m_axi_awaddr, 32'h0);
        repeat (2) @(posedge aclk);
        #3 aresetn = 1;
        @(posedge aclk); #1;
        check("t6_cmd_ready_release", cmd_ready, 1'b1);
        set_slave(0, 0, 0, 0); cfg_rdata = 32'h77; cfg_rresp = 2'b00;
        exp_read(32'h4, 32'h77, 2'b00);
        do_cmd(0, 32'h4, 32'h0, 4'h0); observe(0);
        check("t6_rsp_first", m_rsp_first, 3); check("t6_ar_cnt", m_ar_cnt, 1);
        check("t6_no_aw", m_aw_cnt, 0);

        repeat (3) @(posedge aclk); #1;
        check("sb_empty", exp_aw.size() + exp_w.size() + exp_ar.size() + exp_rsp.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
